// File: rtl/framebuffer_scanout_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : framebuffer_scanout_if
//  Purpose  : Read port of the dual-clock framebuffer as seen from the
//             clk_rd domain. The scanout block is the master: it issues the
//             enable and address. The framebuffer RAM is the slave: it
//             returns data a fixed number of clocks later.
//  Signals  : en_rd    read enable (master -> slave)
//             addr_rd  read address (master -> slave)
//             dout     read data (slave -> master)
//  Revision : 1.0  initial release
// ============================================================================
interface framebuffer_scanout_if #(
  parameter int ADDR_WIDTH = 19,
  parameter int DATA_WIDTH = 8
);
  logic                  en_rd;
  logic [ADDR_WIDTH-1:0] addr_rd;
  logic [DATA_WIDTH-1:0] dout;

  modport master (output en_rd, output addr_rd, input  dout);
  modport slave  (input  en_rd, input  addr_rd, output dout);
endinterface
`default_nettype wire

// File: rtl/framebuffer_scanout.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : framebuffer_scanout
//  Purpose  : Read-side master of the dual-clock framebuffer. It generates
//             VGA raster timing in the clk_rd domain and fetches one
//             framebuffer word per active pixel, with SCALING_FACTOR
//             replication in x and y. Sync, data enable and frame start are
//             delayed to line up with the RAM read latency. The pixel output
//             is blanked while the write side clears the buffer.
//  Ports    : clk_rd       pixel clock (sole clock)
//             rst_n        asynchronous active-low reset
//             fb_busy      framebuffer clear in progress (clk_rd domain)
//             fb           framebuffer read port (master: en_rd, addr_rd; dout in)
//             hsync/vsync  sync pulses, polarity set by SYNC_ACTIVE_LOW
//             de           data enable (active video)
//             pixel        pixel value, 0 whenever de=0
//             frame_start  1-clock pulse with pixel (0,0)
//  Revision : 1.0  initial release
// ============================================================================
module framebuffer_scanout #(
  parameter int FRAME_WIDTH     = 640,
  parameter int FRAME_HEIGHT    = 480,
  parameter int SCALING_FACTOR  = 1,
  parameter int ADDR_WIDTH      = 19,
  parameter int DATA_WIDTH      = 8,
  parameter int H_FRONT         = 16,
  parameter int H_SYNC          = 96,
  parameter int H_BACK          = 48,
  parameter int V_FRONT         = 10,
  parameter int V_SYNC          = 2,
  parameter int V_BACK          = 33,
  parameter int RD_LATENCY      = 1,
  parameter int SYNC_ACTIVE_LOW = 1
) (
  input  wire                   clk_rd,
  input  wire                   rst_n,
  input  wire                   fb_busy,
  framebuffer_scanout_if.master fb,
  output logic                  hsync,
  output logic                  vsync,
  output logic                  de,
  output logic [DATA_WIDTH-1:0] pixel,
  output logic                  frame_start
);

  localparam int H_TOTAL = FRAME_WIDTH + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = FRAME_HEIGHT + V_FRONT + V_SYNC + V_BACK;
  // One extra count of headroom so the exclusive sync end always fits.
  localparam int HW = $clog2(H_TOTAL + 1);
  localparam int VW = $clog2(V_TOTAL + 1);
  localparam int SW = (SCALING_FACTOR > 1) ? $clog2(SCALING_FACTOR) : 1;

  localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT      = HW'(FRAME_WIDTH);
  localparam logic [HW-1:0] H_ACT_LAST = HW'(FRAME_WIDTH - 1);
  localparam logic [HW-1:0] HS_START   = HW'(FRAME_WIDTH + H_FRONT);
  localparam logic [HW-1:0] HS_END     = HW'(FRAME_WIDTH + H_FRONT + H_SYNC);
  localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT      = VW'(FRAME_HEIGHT);
  localparam logic [VW-1:0] VS_START   = VW'(FRAME_HEIGHT + V_FRONT);
  localparam logic [VW-1:0] VS_END     = VW'(FRAME_HEIGHT + V_FRONT + V_SYNC);
  localparam logic [SW-1:0] SUB_LAST   = SW'(SCALING_FACTOR - 1);
  localparam logic [ADDR_WIDTH-1:0] ROW_STEP = ADDR_WIDTH'(FRAME_WIDTH / SCALING_FACTOR);
  localparam logic SYNC_INV = (SYNC_ACTIVE_LOW != 0);

  // Control bundle carried alongside the RAM read.
  localparam int CTL_W    = 5;
  localparam int CTL_DE   = 0;
  localparam int CTL_HS   = 1;
  localparam int CTL_VS   = 2;
  localparam int CTL_FS   = 3;
  localparam int CTL_BUSY = 4;

  // --------------------------------------------------------------------------
  // Raster counters and incremental address generation
  // --------------------------------------------------------------------------
  logic [HW-1:0]         h_cnt_q, h_cnt_d;
  logic [VW-1:0]         v_cnt_q, v_cnt_d;
  logic [SW-1:0]         x_sub_q, x_sub_d;
  logic [SW-1:0]         y_sub_q, y_sub_d;
  logic [ADDR_WIDTH-1:0] col_addr_q, col_addr_d;
  logic [ADDR_WIDTH-1:0] row_base_q, row_base_d;

  logic h_last, v_last, active, hs_on, vs_on, line_end, first_px;

  always_comb begin
    h_last   = (h_cnt_q == H_LAST);
    v_last   = (v_cnt_q == V_LAST);
    active   = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
    hs_on    = (h_cnt_q >= HS_START) && (h_cnt_q < HS_END);
    vs_on    = (v_cnt_q >= VS_START) && (v_cnt_q < VS_END);
    line_end = (h_cnt_q == H_ACT_LAST) && (v_cnt_q < V_ACT);
    first_px = (h_cnt_q == '0) && (v_cnt_q == '0);

    h_cnt_d = h_last ? '0 : h_cnt_q + 1'b1;
    v_cnt_d = v_cnt_q;
    if (h_last) begin
      v_cnt_d = v_last ? '0 : v_cnt_q + 1'b1;
    end

    // Column: each source word is repeated SCALING_FACTOR times per line.
    x_sub_d    = x_sub_q;
    col_addr_d = col_addr_q;
    if (h_last) begin
      x_sub_d    = '0;
      col_addr_d = '0;
    end else if (active) begin
      if (x_sub_q == SUB_LAST) begin
        x_sub_d    = '0;
        col_addr_d = col_addr_q + 1'b1;
      end else begin
        x_sub_d = x_sub_q + 1'b1;
      end
    end

    // Row: each source line is repeated SCALING_FACTOR times per frame.
    y_sub_d    = y_sub_q;
    row_base_d = row_base_q;
    if (h_last && v_last) begin
      y_sub_d    = '0;
      row_base_d = '0;
    end else if (line_end) begin
      if (y_sub_q == SUB_LAST) begin
        y_sub_d    = '0;
        row_base_d = row_base_q + ROW_STEP;
      end else begin
        y_sub_d = y_sub_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_rd or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt_q    <= '0;
      v_cnt_q    <= '0;
      x_sub_q    <= '0;
      y_sub_q    <= '0;
      col_addr_q <= '0;
      row_base_q <= '0;
    end else begin
      h_cnt_q    <= h_cnt_d;
      v_cnt_q    <= v_cnt_d;
      x_sub_q    <= x_sub_d;
      y_sub_q    <= y_sub_d;
      col_addr_q <= col_addr_d;
      row_base_q <= row_base_d;
    end
  end

  // --------------------------------------------------------------------------
  // Fetch stage: read request plus the control bundle for the same pixel
  // --------------------------------------------------------------------------
  logic                  en_rd_q;
  logic [ADDR_WIDTH-1:0] addr_rd_q;
  logic [CTL_W-1:0]      ctl_f_q;

  always_ff @(posedge clk_rd or negedge rst_n) begin
    if (!rst_n) begin
      en_rd_q   <= 1'b0;
      addr_rd_q <= '0;
      ctl_f_q   <= '0;
    end else begin
      en_rd_q   <= active && !fb_busy;
      addr_rd_q <= row_base_q + col_addr_q;
      ctl_f_q   <= {fb_busy, first_px, vs_on, hs_on, active};
    end
  end

  assign fb.en_rd   = en_rd_q;
  assign fb.addr_rd = addr_rd_q;

  // --------------------------------------------------------------------------
  // Alignment delay: RD_LATENCY stages so the bundle meets dout
  // --------------------------------------------------------------------------
  logic [RD_LATENCY*CTL_W-1:0] ctl_sr_q;
  logic [CTL_W-1:0]            ctl_out;

  if (RD_LATENCY == 1) begin : g_align_one
    always_ff @(posedge clk_rd or negedge rst_n) begin
      if (!rst_n) ctl_sr_q <= '0;
      else        ctl_sr_q <= ctl_f_q;
    end
  end else begin : g_align_multi
    always_ff @(posedge clk_rd or negedge rst_n) begin
      if (!rst_n) ctl_sr_q <= '0;
      else        ctl_sr_q <= {ctl_sr_q[(RD_LATENCY-1)*CTL_W-1:0], ctl_f_q};
    end
  end

  assign ctl_out = ctl_sr_q[RD_LATENCY*CTL_W-1 -: CTL_W];

  // --------------------------------------------------------------------------
  // Output register: timing and data leave together
  // --------------------------------------------------------------------------
  logic                  de_q, hsync_q, vsync_q, frame_start_q;
  logic [DATA_WIDTH-1:0] pixel_q, pixel_d;

  // A pixel fetched while the clear was running is not trusted.
  assign pixel_d = (ctl_out[CTL_DE] && !ctl_out[CTL_BUSY]) ? fb.dout : '0;

  always_ff @(posedge clk_rd or negedge rst_n) begin
    if (!rst_n) begin
      de_q          <= 1'b0;
      hsync_q       <= SYNC_INV;
      vsync_q       <= SYNC_INV;
      frame_start_q <= 1'b0;
      pixel_q       <= '0;
    end else begin
      de_q          <= ctl_out[CTL_DE];
      hsync_q       <= ctl_out[CTL_HS] ^ SYNC_INV;
      vsync_q       <= ctl_out[CTL_VS] ^ SYNC_INV;
      frame_start_q <= ctl_out[CTL_FS];
      pixel_q       <= pixel_d;
    end
  end

  assign de          = de_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign frame_start = frame_start_q;
  assign pixel       = pixel_q;

endmodule
`default_nettype wire
